ram_simple_dp_with_re_512x32: RTL and testbench



---
 rtl/ram_simple_dp_with_re_512x32.sv | 54 +++++
 tb/tb_ram_simple_dp_with_re_512x32.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ram_simple_dp_with_re_512x32.sv
// ram_simple_dp_with_re_512x32
//   Simple dual-port RAM, 512 x 32, one write port and one registered read
//   port gated by a read enable. Single clock, synchronous active-high reset
//   that clears only the read register, never the array.
//
//   Ports
//     clock      : single clock, all updates on rising edge
//     reset      : synchronous, active-high; clears dout, blocks writes
//     we         : write enable
//     write_addr : write address (9 bits)
//     din        : write data (32 bits)
//     re         : read enable; dout holds when low
//     read_addr  : read address (9 bits)
//     dout       : registered read data, 1-cycle latency, read-first

module ram_simple_dp_with_re_512x32 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] dout
);

    // Storage; declaration initialisers give the zero power-up contents
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] dout_q = '0;

    // Write port; a write presented during reset is dropped.
    // Explicit ===1 keeps an X/Z enable from being treated as a write.
    always_ff @(posedge clock) begin
        if ((reset === 1'b0) && (we === 1'b1)) begin
            mem[write_addr] <= din;
        end
    end

    // Read register; non-blocking update against the write above gives read-first
    always_ff @(posedge clock) begin
        if (reset) begin
            dout_q <= '0;
        end else if (re === 1'b1) begin
            dout_q <= mem[read_addr];
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_ram_simple_dp_with_re_512x32.sv
// tb_ram_simple_dp_with_re_512x32
//   Self-checking bench: a behavioural memory model predicts dout, a negedge
//   process compares it every cycle, and directed steps pin literal values.

module tb_ram_simple_dp_with_re_512x32;

    logic        clock;
    logic        reset;
    logic        we;
    logic [8:0]  write_addr;
    logic [31:0] din;
    logic        re;
    logic [8:0]  read_addr;
    logic [31:0] dout;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] model_mem [512];
    logic [31:0] exp_dout;
    bit          cmp_on = 1'b0;

    ram_simple_dp_with_re_512x32 dut (
        .clock      (clock),
        .reset      (reset),
        .we         (we),
        .write_addr (write_addr),
        .din        (din),
        .re         (re),
        .read_addr  (read_addr),
        .dout       (dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference behaviour: read sees the word stored before this edge's write
    always @(posedge clock) begin
        if (reset) begin
            exp_dout = 32'h0;
        end else begin
            if (re) exp_dout = model_mem[read_addr];
            if (we) model_mem[write_addr] = din;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
    endtask

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (cmp_on) check("model_cmp", dout, exp_dout);
    end

    // Literal expectation: pins both the DUT and the model
    task automatic check_lit(input string name, input logic [31:0] want);
        check({name, "_dut"}, dout, want);
        check({name, "_model"}, exp_dout, want);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) model_mem[i] = 32'h0;
        exp_dout   = 32'h0;
        reset      = 1'b0;
        we         = 1'b0;
        re         = 1'b0;
        write_addr = 9'h0;
        read_addr  = 9'h0;
        din        = 32'h0;
        #1;
        check_lit("initial_dout", 32'h0);
        cmp_on = 1'b1;

        // 1. Fill upper half, dout must stay 0, then read 300
        for (int i = 0; i < 256; i++) begin
            we = 1'b1; re = 1'b0;
            write_addr = 9'(256 + i);
            din = 32'(i);
            cyc();
        end
        check_lit("fill_dout_zero", 32'h0);
        we = 1'b0; re = 1'b1; read_addr = 9'd300;
        cyc();
        check_lit("read_300", 32'd44);

        // 2. Read-enable hold with a stale address
        re = 1'b0; read_addr = 9'd301;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check_lit("re_hold", 32'd44);
        end
        re = 1'b1;
        cyc();
        check_lit("read_301", 32'd45);

        // 3. Read-during-write at the same address is read-first
        we = 1'b1; re = 1'b0; write_addr = 9'd10; din = 32'hAAAA_AAAA;
        cyc();
        we = 1'b1; re = 1'b1; write_addr = 9'd10; read_addr = 9'd10; din = 32'h5555_5555;
        cyc();
        check_lit("rdw_old", 32'hAAAA_AAAA);
        we = 1'b0;
        cyc();
        check_lit("rdw_new", 32'h5555_5555);

        // 4. Reset clears dout, ignores a concurrent write, leaves the array
        we = 1'b1; re = 1'b0; write_addr = 9'd5; din = 32'hDEAD_BEEF;
        cyc();
        we = 1'b1; write_addr = 9'd20; din = 32'h1234_5678;
        cyc();
        we = 1'b0; re = 1'b1; read_addr = 9'd20;
        cyc();
        check_lit("pre_reset", 32'h1234_5678);
        reset = 1'b1; we = 1'b1; re = 1'b1; write_addr = 9'd5; din = 32'hFFFF_FFFF;
        cyc();
        check_lit("reset_dout", 32'h0);
        reset = 1'b0; we = 1'b0; re = 1'b1; read_addr = 9'd5;
        cyc();
        check_lit("ram5_kept", 32'hDEAD_BEEF);
        read_addr = 9'd20;
        cyc();
        check_lit("ram20_kept", 32'h1234_5678);

        // 5. Concurrent write of upper half and read of lower half
        for (int i = 0; i < 512; i++) begin
            we = 1'b1; re = 1'b1;
            write_addr = 9'(256 + (i % 256));
            read_addr  = 9'(i % 256);
            din        = 32'hC000_0000 | 32'(i);
            cyc();
        end
        we = 1'b0; read_addr = 9'd300;
        cyc();
        check_lit("concurrent_300", 32'hC000_0000 | 32'd300);

        // 6. Random traffic; half the time addresses are narrowed to force collisions
        for (int i = 0; i < 512; i++) begin
            we  = 1'($urandom_range(0, 1));
            re  = 1'($urandom_range(0, 1));
            din = 32'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                write_addr = 9'($urandom_range(0, 7));
                read_addr  = 9'($urandom_range(0, 7));
            end else begin
                write_addr = 9'($urandom_range(0, 511));
                read_addr  = 9'($urandom_range(0, 511));
            end
            cyc();
        end
        we = 1'b0; re = 1'b0;
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
